// File: rtl/tcu_pkg.sv
// Shared types and defaults for the thread coalescing / de-coalescing path.
// Holds the line geometry defaults, the access size code and the scatter FSM states.
package tcu_pkg;

  localparam int DEF_CACHE_LINE_SIZE        = 32;
  localparam int DEF_NUM_MAX_COALESCED_CMDS = DEF_CACHE_LINE_SIZE / 4;
  localparam int DEF_BASE_ADDR_OFFSET       = $clog2(DEF_CACHE_LINE_SIZE);

  localparam int TID_W      = 10;
  localparam int BLOCK_ID_W = 4;
  localparam int REG_W      = 7;
  localparam int WB_DATA_W  = 64;

  typedef enum logic [1:0] {
    SZ_1B = 2'd0,
    SZ_2B = 2'd1,
    SZ_4B = 2'd2,
    SZ_8B = 2'd3
  } size_e;

  typedef enum logic {
    IDLE    = 1'b0,
    SCATTER = 1'b1
  } scatter_state_e;

  // Keeps the low (1 << sz) bytes of a writeback word.
  function automatic logic [WB_DATA_W-1:0] size_mask(input size_e sz);
    logic [WB_DATA_W-1:0] m;
    m = '0;
    case (sz)
      SZ_1B:   m = 64'h0000_0000_0000_00FF;
      SZ_2B:   m = 64'h0000_0000_0000_FFFF;
      SZ_4B:   m = 64'h0000_0000_FFFF_FFFF;
      SZ_8B:   m = 64'hFFFF_FFFF_FFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tcu_resp_scatter_if.sv
// Coalesced-response input channel and per-thread writeback channel of the scatter unit.
// Handshakes: a transfer happens on a rising edge where valid && ready; a source holds
// valid and its payload stable until that edge and never withdraws valid before it.
interface tcu_resp_scatter_if
  import tcu_pkg::*;
#(
  parameter int CACHE_LINE_SIZE        = DEF_CACHE_LINE_SIZE,
  parameter int NUM_MAX_COALESCED_CMDS = CACHE_LINE_SIZE / 4,
  parameter int BASE_ADDR_OFFSET       = $clog2(CACHE_LINE_SIZE)
);

  logic                                                  resp_valid;
  logic                                                  resp_ready;
  logic [BLOCK_ID_W-1:0]                                 resp_block_id;
  logic [TID_W-1:0]                                      resp_base_tid;
  logic [NUM_MAX_COALESCED_CMDS-1:0]                     resp_tid_bitmap;
  logic [CACHE_LINE_SIZE*8-1:0]                          resp_data;
  logic [1:0]                                            resp_size;
  logic [REG_W-1:0]                                      resp_ld_dest_reg;
  logic [NUM_MAX_COALESCED_CMDS-1:0][BASE_ADDR_OFFSET-1:0] resp_address_map;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [BLOCK_ID_W-1:0] wb_block_id;
  logic [TID_W-1:0]      wb_tid;
  logic [WB_DATA_W-1:0]  wb_data;
  logic [REG_W-1:0]      wb_ld_dest_reg;

  scatter_state_e        dbg_state;

  // Response source and writeback sink side.
  modport master (
    output resp_valid, resp_block_id, resp_base_tid, resp_tid_bitmap, resp_data,
           resp_size, resp_ld_dest_reg, resp_address_map, wb_ready,
    input  resp_ready, wb_valid, wb_block_id, wb_tid, wb_data, wb_ld_dest_reg, dbg_state
  );

  // Scatter unit side.
  modport slave (
    input  resp_valid, resp_block_id, resp_base_tid, resp_tid_bitmap, resp_data,
           resp_size, resp_ld_dest_reg, resp_address_map, wb_ready,
    output resp_ready, wb_valid, wb_block_id, wb_tid, wb_data, wb_ld_dest_reg, dbg_state
  );

endinterface

// File: rtl/tcu_lowest_set_pe.sv
// Lowest-set-bit priority encoder: index of the least significant 1 plus an any-set flag.
module tcu_lowest_set_pe #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning downward lets the lowest set bit win the last assignment.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcu_resp_scatter.sv
// De-coalescing response unit: holds one coalesced cache-line load response and emits
// one per-thread writeback beat per cycle, lowest participating thread first.
module tcu_resp_scatter
  import tcu_pkg::*;
#(
  parameter int CACHE_LINE_SIZE        = DEF_CACHE_LINE_SIZE,
  parameter int NUM_MAX_COALESCED_CMDS = CACHE_LINE_SIZE / 4,
  parameter int BASE_ADDR_OFFSET       = $clog2(CACHE_LINE_SIZE)
) (
  input logic               clk,
  input logic               rst_n,
  tcu_resp_scatter_if.slave bus
);

  localparam int NUM    = NUM_MAX_COALESCED_CMDS;
  localparam int OFF_W  = BASE_ADDR_OFFSET;
  localparam int LINE_W = CACHE_LINE_SIZE * 8;
  localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;

  scatter_state_e state_q;
  scatter_state_e state_d;

  logic [BLOCK_ID_W-1:0]       held_block_id;
  logic [TID_W-1:0]            held_base_tid;
  logic [NUM-1:0]              held_bitmap;
  logic [LINE_W-1:0]           held_data;
  size_e                       held_size;
  logic [REG_W-1:0]            held_dest;
  logic [NUM-1:0][OFF_W-1:0]   held_map;

  logic [IDX_W-1:0]  idx;
  logic              any_set;
  logic [NUM-1:0]    idx_onehot;
  logic [NUM-1:0]    remaining;
  logic              last_beat;
  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  shift_bits;

  logic load;
  logic consume;

  tcu_lowest_set_pe #(
    .WIDTH (NUM)
  ) u_pe (
    .vec (held_bitmap),
    .idx (idx),
    .any (any_set)
  );

  assign idx_onehot = NUM'(1) << idx;
  assign remaining  = held_bitmap & ~idx_onehot;
  assign last_beat  = (remaining == '0);

  assign off        = held_map[idx];
  assign shift_bits = {off, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // resp_ready reaches wb_ready combinationally only on the completing beat, so a new
  // response can be loaded underneath the last beat of the current one.
  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    consume         = 1'b0;
    bus.resp_ready  = 1'b0;
    bus.wb_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.resp_ready = 1'b1;
        if (bus.resp_valid) begin
          load    = 1'b1;
          state_d = (bus.resp_tid_bitmap != '0) ? SCATTER : IDLE;
        end
      end
      SCATTER: begin
        bus.wb_valid = any_set;
        if (bus.wb_ready && any_set) begin
          consume = 1'b1;
          if (last_beat) begin
            bus.resp_ready = 1'b1;
            if (bus.resp_valid) begin
              load    = 1'b1;
              state_d = (bus.resp_tid_bitmap != '0) ? SCATTER : IDLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_block_id <= '0;
      held_base_tid <= '0;
      held_bitmap   <= '0;
      held_data     <= '0;
      held_size     <= SZ_1B;
      held_dest     <= '0;
      held_map      <= '0;
    end else if (load) begin
      held_block_id <= bus.resp_block_id;
      held_base_tid <= bus.resp_base_tid;
      held_bitmap   <= bus.resp_tid_bitmap;
      held_data     <= bus.resp_data;
      held_size     <= size_e'(bus.resp_size);
      held_dest     <= bus.resp_ld_dest_reg;
      held_map      <= bus.resp_address_map;
    end else if (consume) begin
      held_bitmap   <= remaining;
    end
  end

  // Barrel shift brings byte 'off' to bit 0; bytes shifted in from beyond the line are 0.
  assign bus.wb_data        = WB_DATA_W'(held_data >> shift_bits) & size_mask(held_size);
  assign bus.wb_tid         = held_base_tid + TID_W'(idx);
  assign bus.wb_block_id    = held_block_id;
  assign bus.wb_ld_dest_reg = held_dest;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_tcu_resp_scatter.sv
// Bench for tcu_resp_scatter: directed cases plus randomized responses checked
// against a byte-level model of the scatter rules.
module tb_tcu_resp_scatter;
  import tcu_pkg::*;

  localparam int CLS    = 32;
  localparam int NT     = CLS / 4;
  localparam int BEAT_W = 85;  // {block[4], tid[10], data[64], dest[7]}

  logic clk;
  logic rst_n;

  tcu_resp_scatter_if bus ();

  tcu_resp_scatter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] obs_q[$];
  int                obs_cyc[$];
  int                acc_cyc[$];

  logic              stall_pending = 1'b0;
  logic [BEAT_W-1:0] stall_snap;

  int   ready_mode   = 0;   // 0: always ready, 1: random, 2: manual_ready
  logic manual_ready = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: byte b of the result is line byte off+b for b < 2^size, 0 past the line end.
  function automatic logic [63:0] pick(input logic [CLS*8-1:0] line, input int off, input int sz);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < (1 << sz); b++) begin
      if (off + b < CLS) r[b*8 +: 8] = line[(off + b)*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [CLS*8-1:0] index_line();
    logic [CLS*8-1:0] l;
    for (int b = 0; b < CLS; b++) l[b*8 +: 8] = 8'(b);
    return l;
  endfunction

  function automatic logic [BEAT_W-1:0] cur_beat();
    return {bus.wb_block_id, bus.wb_tid, bus.wb_data, bus.wb_ld_dest_reg};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [BEAT_W-1:0] e;
    logic [BEAT_W-1:0] o;
    cyc++;
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (bus.wb_valid) begin
        o = cur_beat();
        if (stall_pending) check("wb_stable", 64'(o != stall_snap), 64'd0);
        if (bus.wb_ready) begin
          stall_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("spurious_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("wb_tid",   64'(o[80:71]), 64'(e[80:71]));
            check("wb_data",  o[70:7],       e[70:7]);
            check("wb_block", 64'(o[84:81]), 64'(e[84:81]));
            check("wb_dest",  64'(o[6:0]),   64'(e[6:0]));
          end
          obs_q.push_back(o);
          obs_cyc.push_back(cyc);
        end else begin
          stall_pending = 1'b1;
          stall_snap    = o;
        end
      end else if (stall_pending) begin
        check("wb_valid_dropped", 64'd0, 64'd1);
        stall_pending = 1'b0;
      end
      if (bus.resp_valid && bus.resp_ready) begin
        acc_cyc.push_back(cyc);
        for (int i = 0; i < NT; i++) begin
          if (bus.resp_tid_bitmap[i]) begin
            exp_q.push_back({bus.resp_block_id,
                             10'((int'(bus.resp_base_tid) + i) % 1024),
                             pick(bus.resp_data, int'(bus.resp_address_map[i]), int'(bus.resp_size)),
                             bus.resp_ld_dest_reg});
          end
        end
      end
    end
  end

  // ---------------- writeback sink driver ----------------
  initial begin
    bus.wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.wb_ready = 1'b1;
        1:       bus.wb_ready = ($urandom_range(0, 3) != 0);
        default: bus.wb_ready = manual_ready;
      endcase
    end
  end

  // ---------------- response driver tasks ----------------
  task automatic send_resp(input logic [3:0] blk, input logic [9:0] base, input logic [NT-1:0] bm,
                           input logic [1:0] sz, input logic [6:0] dest,
                           input logic [NT-1:0][4:0] map, input logic [CLS*8-1:0] line);
    int   n;
    logic acc;
    bus.resp_valid       = 1'b1;
    bus.resp_block_id    = blk;
    bus.resp_base_tid    = base;
    bus.resp_tid_bitmap  = bm;
    bus.resp_size        = sz;
    bus.resp_ld_dest_reg = dest;
    bus.resp_address_map = map;
    bus.resp_data        = line;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.resp_ready;
      n++;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.resp_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.wb_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    obs_q.delete();
    obs_cyc.delete();
    acc_cyc.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [NT-1:0][4:0] map;
    logic [CLS*8-1:0]   line;
    logic [CLS*8-1:0]   rline;
    int                 cnt;

    rst_n                = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_block_id    = '0;
    bus.resp_base_tid    = '0;
    bus.resp_tid_bitmap  = '0;
    bus.resp_size        = '0;
    bus.resp_ld_dest_reg = '0;
    bus.resp_address_map = '0;
    bus.resp_data        = '0;
    line                 = index_line();

    idle_cycles(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_resp_ready", 64'(bus.resp_ready),     64'd1);
    check("rst_wb_valid",   64'(bus.wb_valid),       64'd0);
    check("rst_wb_block",   64'(bus.wb_block_id),    64'd0);
    check("rst_wb_tid",     64'(bus.wb_tid),         64'd0);
    check("rst_wb_data",    bus.wb_data,             64'd0);
    check("rst_wb_dest",    64'(bus.wb_ld_dest_reg), 64'd0);
    check("rst_state",      64'(bus.dbg_state),      64'(IDLE));
    @(posedge clk);
    #1;

    // Two-thread response, sink always ready.
    clear_logs();
    map    = '0;
    map[2] = 5'd8;
    send_resp(4'd3, 10'd100, 8'b0000_0101, 2'd2, 7'd9, map, line);
    wait_drain();
    check("t1_beats",   64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("t1_tid0",    64'(obs_q[0][80:71]), 64'd100);
      check("t1_data0",   obs_q[0][70:7],       64'h0302_0100);
      check("t1_tid1",    64'(obs_q[1][80:71]), 64'd102);
      check("t1_data1",   obs_q[1][70:7],       64'h0B0A_0908);
      check("t1_latency", 64'(obs_cyc[0] - acc_cyc[0]), 64'd1);
      check("t1_rate",    64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
    end

    // Same response with the sink stalled for three cycles on the first beat.
    clear_logs();
    ready_mode   = 2;
    manual_ready = 1'b0;
    idle_cycles(1);
    send_resp(4'd3, 10'd100, 8'b0000_0101, 2'd2, 7'd9, map, line);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_resp_ready", 64'(bus.resp_ready), 64'd0);
      check("stall_wb_valid",   64'(bus.wb_valid),   64'd1);
    end
    manual_ready = 1'b1;
    wait_drain();
    ready_mode = 0;
    check("t2_beats", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("t2_tid0", 64'(obs_q[0][80:71]), 64'd100);
      check("t2_tid1", 64'(obs_q[1][80:71]), 64'd102);
    end

    // Back-to-back responses, second one wrapping the TID space.
    clear_logs();
    send_resp(4'd1, 10'd0,    8'h01, 2'd0, 7'd1, '0, line);
    send_resp(4'd2, 10'd1020, 8'h80, 2'd1, 7'd2, '0, line);
    wait_drain();
    check("b2b_beats", 64'(obs_q.size()), 64'd2);
    if (obs_q.size() == 2) begin
      check("b2b_tid0",   64'(obs_q[0][80:71]), 64'd0);
      check("b2b_tid1",   64'(obs_q[1][80:71]), 64'd3);
      check("b2b_bubble", 64'(obs_cyc[1] - obs_cyc[0]), 64'd1);
    end

    // Zero bitmap is dropped; the next response goes in the following cycle.
    clear_logs();
    send_resp(4'd5, 10'd7, 8'h00, 2'd3, 7'd5, '0, line);
    send_resp(4'd6, 10'd8, 8'h01, 2'd0, 7'd6, '0, line);
    wait_drain();
    check("zero_beats", 64'(obs_q.size()), 64'd1);
    if (acc_cyc.size() == 2) check("zero_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
    else check("zero_accepts", 64'(acc_cyc.size()), 64'd2);

    // 8-byte access starting two bytes before the end of the line.
    clear_logs();
    map    = '0;
    map[0] = 5'd30;
    send_resp(4'd7, 10'd50, 8'h01, 2'd3, 7'd7, map, line);
    wait_drain();
    check("edge_beats", 64'(obs_q.size()), 64'd1);
    if (obs_q.size() == 1) check("edge_data", obs_q[0][70:7], 64'h0000_0000_0000_1F1E);

    // Reset asserted after the first of four beats.
    clear_logs();
    send_resp(4'd8, 10'd200, 8'h0F, 2'd2, 7'd8, '0, line);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wb_valid",   64'(bus.wb_valid),   64'd0);
    check("mid_rst_resp_ready", 64'(bus.resp_ready), 64'd1);
    exp_q.delete();
    cnt = obs_q.size();
    idle_cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_wb_valid",   64'(bus.wb_valid),   64'd0);
      check("post_rst_resp_ready", 64'(bus.resp_ready), 64'd1);
    end
    check("post_rst_residual", 64'(obs_q.size() - cnt), 64'd0);
    @(posedge clk);
    #1;

    // Randomized responses with a randomly stalling sink.
    ready_mode = 1;
    for (int r = 0; r < 250; r++) begin
      logic [NT-1:0] bm;
      for (int w = 0; w < CLS / 4; w++) rline[w*32 +: 32] = $urandom();
      for (int i = 0; i < NT; i++) map[i] = 5'($urandom_range(0, CLS - 1));
      bm = ($urandom_range(0, 5) == 0) ? '0 : NT'($urandom());
      send_resp(4'($urandom()), 10'($urandom()), bm, 2'($urandom_range(0, 3)),
                7'($urandom()), map, rline);
      idle_cycles($urandom_range(0, 2));
    end
    wait_drain();
    ready_mode = 0;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
